fir_output_stage: RTL and testbench

//  Downstream of fir_filter: takes each full-precision accumulator result and its
//  one-cycle valid strobe, then rounds, saturates and decimates it.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_output_stage_if.sv | 35 +++
 rtl/fir_sync_fifo.sv | 75 +++++++
 rtl/fir_output_stage.sv | 133 +++++++++++++
 tb/tb_fir_output_stage.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg
//   Constants and helper functions shared by the FIR filter and its output
//   stage: accumulator width derivation, signed saturation limits and the
//   round-half-up constant.
package fir_pkg;

  // Full-precision accumulator width of a NUM_OF_TAPS filter.
  function automatic int acc_width(input int taps, input int in_w, input int coef_w);
    return in_w + coef_w + $clog2(taps);
  endfunction

  // Largest value of a signed number of the given width.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Smallest value of a signed number of the given width.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

  // Half of one output LSB when SHIFT bits are dropped.
  function automatic int round_const(input int shift);
    return 1 << (shift - 1);
  endfunction

endpackage

// File: rtl/fir_output_stage_if.sv
// fir_output_stage_if
//   Sample stream into and out of the FIR output stage.
//   acc_data/acc_data_flag : accumulator result and its single-cycle strobe
//   out_data/out_valid     : sample at the FIFO head, FIFO not empty
//   out_ready              : sink accepts out_data when out_valid is high
//   master : the side feeding accumulator results and consuming samples
//   slave  : the output stage itself
interface fir_output_stage_if
  import fir_pkg::*;
#(
  parameter int ACC_WIDTH    = acc_width(3, 8, 8),
  parameter int OUTPUT_WIDTH = 8
);
  logic signed [ACC_WIDTH-1:0]    acc_data;
  logic                           acc_data_flag;
  logic signed [OUTPUT_WIDTH-1:0] out_data;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output acc_data,
    output acc_data_flag,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  acc_data,
    input  acc_data_flag,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo
//   Small synchronous FIFO with an occupancy counter. The head is shown
//   combinationally and reads as zero while empty. A push into a full FIFO
//   is accepted only if a pop happens in the same cycle. clear_i flushes the
//   FIFO and overrides any push/pop in that cycle.
//   Ports: clk, rst_n (async, active low), clear_i, push_i, data_i, pop_i,
//          full_o, empty_o, head_o.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap by themselves.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/fir_output_stage.sv
// fir_output_stage
//   Rounds (half-up toward +inf), saturates and decimates full-precision
//   accumulator results, then buffers surviving samples in a FIFO behind a
//   valid/ready output. The upstream strobe is never stalled; a kept sample
//   arriving at a full FIFO with no pop is dropped and flagged.
//   Ports: clk, rst_n (async, active low), clear_i (sync flush),
//          bus (slave: acc_data, acc_data_flag, out_ready in;
//               out_data, out_valid out),
//          overflow_o (sticky drop flag), sat_count_o (saturating count of
//          clamped samples).
module fir_output_stage
  import fir_pkg::*;
#(
  parameter int NUM_OF_TAPS   = 3,
  parameter int INPUT_WIDTH   = 8,
  parameter int COEF_WIDTH    = 8,
  parameter int ACC_WIDTH     = acc_width(NUM_OF_TAPS, INPUT_WIDTH, COEF_WIDTH),
  parameter int OUTPUT_WIDTH  = 8,
  parameter int SHIFT         = 8,
  parameter int DECIM         = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int SAT_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  fir_output_stage_if.slave        bus,
  output logic                     overflow_o,
  output logic [SAT_CNT_WIDTH-1:0] sat_count_o
);
  // One guard bit keeps acc + round constant from wrapping.
  localparam int EXT_W  = ACC_WIDTH + 1;
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [EXT_W-1:0] RND     = EXT_W'(round_const(SHIFT));
  localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(sat_max(OUTPUT_WIDTH));
  localparam logic signed [EXT_W-1:0] MIN_EXT = EXT_W'(sat_min(OUTPUT_WIDTH));
  localparam logic [DCNT_W-1:0]       DCNT_RELOAD = DCNT_W'(DECIM - 1);

  logic signed [EXT_W-1:0]        acc_ext, rnd_sum, rnd_shr;
  logic signed [OUTPUT_WIDTH-1:0] sat_val;
  logic                           sat_hit;

  logic                           s1_valid_q, s1_valid_d;
  logic signed [OUTPUT_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [DCNT_W-1:0]              dcnt_q, dcnt_d;
  logic                           overflow_q, overflow_d;
  logic [SAT_CNT_WIDTH-1:0]       sat_cnt_q, sat_cnt_d;

  logic                           push, pop;
  logic                           fifo_full, fifo_empty;
  logic [OUTPUT_WIDTH-1:0]        fifo_head;

  always_comb begin
    acc_ext = $signed({bus.acc_data[ACC_WIDTH-1], bus.acc_data});
    rnd_sum = acc_ext + RND;
    rnd_shr = rnd_sum >>> SHIFT;
    sat_hit = 1'b1;
    if (rnd_shr > MAX_EXT) begin
      sat_val = OUTPUT_WIDTH'(MAX_EXT);
    end else if (rnd_shr < MIN_EXT) begin
      sat_val = OUTPUT_WIDTH'(MIN_EXT);
    end else begin
      sat_val = OUTPUT_WIDTH'(rnd_shr);
      sat_hit = 1'b0;
    end
  end

  assign pop = ~fifo_empty & bus.out_ready;

  // Decimation uses a down-counter: a stage-1 sample is kept when the count
  // is zero, which then reloads to DECIM-1, giving 1 kept in every DECIM.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    dcnt_d     = dcnt_q;
    overflow_d = overflow_q;
    sat_cnt_d  = sat_cnt_q;
    push       = 1'b0;
    if (clear_i) begin
      s1_data_d  = '0;
      dcnt_d     = '0;
      overflow_d = 1'b0;
      sat_cnt_d  = '0;
    end else begin
      if (bus.acc_data_flag) begin
        s1_valid_d = 1'b1;
        s1_data_d  = sat_val;
        if (sat_hit && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
      end
      if (s1_valid_q) begin
        push   = (dcnt_q == '0);
        dcnt_d = push ? DCNT_RELOAD : dcnt_q - 1'b1;
      end
      if (push && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      dcnt_q     <= '0;
      overflow_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      dcnt_q     <= dcnt_d;
      overflow_q <= overflow_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (s1_data_q),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_head;
  assign overflow_o    = overflow_q;
  assign sat_count_o   = sat_cnt_q;
endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage
//   Two output stages (DECIM=1 and DECIM=3) fed the same stream, each
//   compared every cycle against a queue-based reference model, plus
//   directed scenarios for rounding, saturation, back-pressure, decimation,
//   clear and asynchronous reset.
module tb_fir_output_stage;
  import fir_pkg::*;

  localparam int AW    = 18;
  localparam int OW    = 8;
  localparam int DEPTH = 4;
  localparam int DEC_A = 1;
  localparam int DEC_B = 3;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 flag  = 1'b0;
  logic                 ready = 1'b1;
  logic signed [AW-1:0] acc   = '0;
  logic                 ovf1, ovf3;
  logic [7:0]           sat1, sat3;

  int n_tests = 0;
  int n_fail  = 0;

  fir_output_stage_if #(.ACC_WIDTH(AW), .OUTPUT_WIDTH(OW)) bus1 ();
  fir_output_stage_if #(.ACC_WIDTH(AW), .OUTPUT_WIDTH(OW)) bus3 ();

  assign bus1.acc_data      = acc;
  assign bus1.acc_data_flag = flag;
  assign bus1.out_ready     = ready;
  assign bus3.acc_data      = acc;
  assign bus3.acc_data_flag = flag;
  assign bus3.out_ready     = ready;

  fir_output_stage #(.DECIM(DEC_A)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .bus         (bus1),
    .overflow_o  (ovf1),
    .sat_count_o (sat1)
  );

  fir_output_stage #(.DECIM(DEC_B)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .bus         (bus3),
    .overflow_o  (ovf3),
    .sat_count_o (sat3)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (index 0: DECIM=1, 1: DECIM=3) -----
  int mq   [2][$];
  int got  [2][$];
  bit ms1v [2];
  int ms1d [2];
  int midx [2];
  bit movf [2];
  int msat [2];

  function automatic int dec_of(input int i);
    return (i == 0) ? DEC_A : DEC_B;
  endfunction

  // floor((a + 128) / 256) with plain integer division.
  function automatic int round_q(input int a);
    int t;
    t = a + 128;
    if (t >= 0) return t / 256;
    return -((-t + 255) / 256);
  endfunction

  task automatic model_step(input int i);
    bit do_pop;
    int r;
    if (clear) begin
      mq[i].delete();
      ms1v[i] = 1'b0;
      midx[i] = 0;
      movf[i] = 1'b0;
      msat[i] = 0;
      return;
    end
    do_pop = (mq[i].size() > 0) && ready;
    if (do_pop) void'(mq[i].pop_front());
    if (ms1v[i]) begin
      if ((midx[i] % dec_of(i)) == 0) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(ms1d[i]);
        else                      movf[i] = 1'b1;
      end
      midx[i]++;
    end
    ms1v[i] = flag;
    if (flag) begin
      r = round_q(int'(acc));
      if (r > 127 || r < -128) begin
        r = (r > 127) ? 127 : -128;
        if (msat[i] < 255) msat[i]++;
      end
      ms1d[i] = r;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        ms1v[i] = 1'b0;
        midx[i] = 0;
        movf[i] = 1'b0;
        msat[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- checking -------------------------------------------
  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_cycle(input int i, input logic v, input logic signed [OW-1:0] d,
                           input logic o, input logic [7:0] s);
    int ev, ed;
    ev = (mq[i].size() > 0) ? 1 : 0;
    ed = (ev == 1) ? mq[i][0] : 0;
    chk_eq((i == 0) ? "m_valid1" : "m_valid3", int'(v), ev);
    chk_eq((i == 0) ? "m_data1"  : "m_data3",  int'(d), ed);
    chk_eq((i == 0) ? "m_ovf1"   : "m_ovf3",   int'(o), int'(movf[i]));
    chk_eq((i == 0) ? "m_sat1"   : "m_sat3",   int'(s), msat[i]);
    if (v && ready && !clear && rst_n) got[i].push_back(int'(d));
  endtask

  always @(negedge clk) begin
    chk_cycle(0, bus1.out_valid, bus1.out_data, ovf1, sat1);
    chk_cycle(1, bus3.out_valid, bus3.out_data, ovf3, sat3);
  end

  function automatic int q_at(input int i, input int k);
    if (k < got[i].size()) return got[i][k];
    return -9999;
  endfunction

  // ---------------- stimulus helpers -----------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int a);
    @(posedge clk); #1;
    acc  = AW'(a);
    flag = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  int r_acc [4] = '{384, 255, -384, -385};
  int r_exp [4] = '{2, 1, -1, -2};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_flag;
    int v;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_valid", int'(bus1.out_valid), 0);
    chk_eq("rst_data",  int'(bus1.out_data), 0);
    chk_eq("rst_ovf",   int'(ovf1), 0);
    chk_eq("rst_sat",   int'(sat1), 0);

    // Rounding and two-cycle latency.
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(r_acc[i]);
      @(negedge clk);
      chk_eq("lat_early", int'(bus1.out_valid), 0);
      @(negedge clk);
      chk_eq("lat_valid", int'(bus1.out_valid), 1);
      chk_eq("round",     int'(bus1.out_data), r_exp[i]);
    end

    // Saturation; the DECIM=3 stage counts the dropped clamp too.
    pulse_clear();
    got[0].delete();
    got[1].delete();
    strobe(40000);
    strobe(-40000);
    idle(5);
    chk_eq("sat_cnt1",  int'(sat1), 2);
    chk_eq("sat_cnt3",  int'(sat3), 2);
    chk_eq("sat_ovf",   int'(ovf1), 0);
    chk_eq("sat_n",     got[0].size(), 2);
    chk_eq("sat_max",   q_at(0, 0), 127);
    chk_eq("sat_min",   q_at(0, 1), -128);
    chk_eq("sat_dec_n", got[1].size(), 1);

    // Back-pressure: five strobes into a four-entry FIFO.
    pulse_clear();
    got[0].delete();
    got[1].delete();
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      strobe(256 * k);
      idle(8);
    end
    chk_eq("bp_ovf",    int'(ovf1), 1);
    chk_eq("bp_held",   int'(bus1.out_valid), 1);
    chk_eq("bp_ovf3",   int'(ovf3), 0);
    ready = 1'b1;
    idle(8);
    chk_eq("bp_n", got[0].size(), 4);
    for (int k = 0; k < 4; k++) chk_eq("bp_order", q_at(0, k), k + 1);
    chk_eq("bp_empty", int'(bus1.out_valid), 0);

    // Full FIFO with a pop in the push cycle: nothing is lost.
    pulse_clear();
    got[0].delete();
    got[1].delete();
    ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      strobe(256 * k);
      idle(1);
    end
    idle(3);
    strobe(256 * 5);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    idle(3);
    chk_eq("fp_ovf", int'(ovf1), 0);
    ready = 1'b1;
    idle(8);
    chk_eq("fp_n", got[0].size(), 5);
    for (int k = 0; k < 5; k++) chk_eq("fp_order", q_at(0, k), k + 1);

    // Decimation by 3, then clear restarting the decimation phase.
    pulse_clear();
    got[1].delete();
    for (int k = 1; k <= 6; k++) begin
      strobe(256 * k);
      idle(2);
    end
    idle(4);
    chk_eq("dec_n",  got[1].size(), 2);
    chk_eq("dec_k0", q_at(1, 0), 1);
    chk_eq("dec_k1", q_at(1, 1), 4);
    pulse_clear();
    got[1].delete();
    strobe(256);
    idle(2);
    strobe(512);
    pulse_clear();
    strobe(768);
    idle(5);
    chk_eq("dclr_n",  got[1].size(), 2);
    chk_eq("dclr_k0", q_at(1, 0), 1);
    chk_eq("dclr_k1", q_at(1, 1), 3);

    // Asynchronous reset with three entries buffered.
    pulse_clear();
    ready = 1'b0;
    strobe(40000);
    strobe(256);
    strobe(512);
    idle(3);
    chk_eq("ar_pre_valid", int'(bus1.out_valid), 1);
    chk_eq("ar_pre_sat",   int'(sat1), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_eq("ar_valid1", int'(bus1.out_valid), 0);
    chk_eq("ar_valid3", int'(bus3.out_valid), 0);
    chk_eq("ar_data",   int'(bus1.out_data), 0);
    chk_eq("ar_sat",    int'(sat1), 0);
    #3 rst_n = 1'b1;
    ready = 1'b1;
    idle(2);
    chk_eq("ar_post_valid", int'(bus1.out_valid), 0);
    chk_eq("ar_post_ovf",   int'(ovf1), 0);
    chk_eq("ar_post_sat",   int'(sat1), 0);
    chk_eq("ar_post_sat3",  int'(sat3), 0);

    // Randomized traffic, checked every cycle against the model.
    prev_flag = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      flag  = !prev_flag && ($urandom_range(0, 1) == 1);
      prev_flag = flag;
      ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 2))
        0:       v = int'($urandom_range(0, 262143)) - 131072;
        1:       v = int'($urandom_range(0, 4000)) - 2000;
        default: v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(32500, 32900))
                                                 : -int'($urandom_range(32500, 33000));
      endcase
      acc = AW'(v);
    end
    flag  = 1'b0;
    clear = 1'b0;
    ready = 1'b1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
